regfile_mp: RTL



---
 rtl/regfile_mp.sv | 80 ++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two byte-enabled write ports and a per-register busy scoreboard.
// Optional write-to-read forwarding is selected with the RF_BYPASS_EN macro; the default build shows pre-edge state.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter logic [DATA_W-1:0] GP_INIT = 'h0000_1800,
  parameter logic [DATA_W-1:0] SP_INIT = 'h0000_2ffc
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic [DATA_W/8-1:0]      wbe0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [DATA_W/8-1:0]      wbe1,
  input  logic                     bs_vld,
  input  logic [ADDR_W-1:0]        bs_addr,
  output logic                     any_busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  // Value register `a` takes at the next edge; port 1 is applied last so it owns any byte it enables.
  function automatic logic [DATA_W-1:0] merged(input logic [DATA_W-1:0] cur,
                                               input logic [ADDR_W-1:0] a);
    merged = cur;
    if (a != '0) begin
      for (int b = 0; b < NB; b++) begin
        if (we0 && wa0 == a && wbe0[b]) merged[b*8 +: 8] = wd0[b*8 +: 8];
        if (we1 && wa1 == a && wbe1[b]) merged[b*8 +: 8] = wd1[b*8 +: 8];
      end
    end
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == 28)      regs[i] <= GP_INIT;
        else if (i == 29) regs[i] <= SP_INIT;
        else              regs[i] <= '0;
      end
      busy <= '0;
    end else begin
      // Register 0 is never written after reset, so it stays zero and never busy.
      for (int i = 1; i < DEPTH; i++) begin
        regs[i] <= merged(regs[i], ADDR_W'(i));
        if (bs_vld && bs_addr == ADDR_W'(i))  busy[i] <= 1'b1;
        else if (we1 && wa1 == ADDR_W'(i))    busy[i] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : gRd
    logic [ADDR_W-1:0] rdA;
    assign rdA = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
    logic clearNow;
    assign clearNow = we1 && wa1 == rdA && !(bs_vld && bs_addr == rdA);
    assign rd_data[k*DATA_W +: DATA_W] = merged(regs[rdA], rdA);
    assign rd_busy[k] = busy[rdA] && !clearNow;
`else
    assign rd_data[k*DATA_W +: DATA_W] = regs[rdA];
    assign rd_busy[k] = busy[rdA];
`endif
  end

  assign any_busy = |busy;

endmodule
